// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - FP16 field widths, rounding-mode encodings and canonical constants
package fpu_pkg;

  localparam int FP_WIDTH  = 11;
  localparam int FP_FRAC_W = 10;
  localparam int FP_EXP_W  = 5;
  localparam int FP_BIAS   = 15;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rm_e;

  localparam logic [15:0] FP_QNAN    = 16'h7E00;
  localparam logic [15:0] FP_INF     = 16'h7C00;
  localparam logic [15:0] FP_MAX_FIN = 16'h7BFF;

  function automatic logic [15:0] fp_pack(input logic s, input logic [FP_EXP_W-1:0] e,
                                          input logic [FP_FRAC_W-1:0] f);
    return {s, e, f};
  endfunction

endpackage

// File: rtl/fpmul_round_pack_if.sv
// rtl/fpmul_round_pack_if.sv - beat-in/result-out handshake bundle; rm present only with FPMUL_RMODE_EN
interface fpmul_round_pack_if #(
  parameter int WIDTH = fpu_pkg::FP_WIDTH,
  parameter int EXP_W = fpu_pkg::FP_EXP_W
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2*WIDTH-1:0]     prod;
  logic [EXP_W+1:0]       exp_in;
  logic                   sign_in;
  logic                   is_nan;
  logic                   is_inf;
  logic                   is_zero;
`ifdef FPMUL_RMODE_EN
  logic [1:0]             rm;
`endif
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+WIDTH-1:0] result;
  logic                   flag_ovf;
  logic                   flag_unf;
  logic                   flag_inx;

`ifdef FPMUL_RMODE_EN
  modport master (output in_valid, prod, exp_in, sign_in, is_nan, is_inf, is_zero, rm, out_ready,
                  input  in_ready, out_valid, result, flag_ovf, flag_unf, flag_inx);
  modport slave  (input  in_valid, prod, exp_in, sign_in, is_nan, is_inf, is_zero, rm, out_ready,
                  output in_ready, out_valid, result, flag_ovf, flag_unf, flag_inx);
`else
  modport master (output in_valid, prod, exp_in, sign_in, is_nan, is_inf, is_zero, out_ready,
                  input  in_ready, out_valid, result, flag_ovf, flag_unf, flag_inx);
  modport slave  (input  in_valid, prod, exp_in, sign_in, is_nan, is_inf, is_zero, out_ready,
                  output in_ready, out_valid, result, flag_ovf, flag_unf, flag_inx);
`endif

endinterface

// File: rtl/fpmul_round_inc.sv
// rtl/fpmul_round_inc.sv - rounding increment decision and fraction carry, shared by FP rounders
module fpmul_round_inc
  import fpu_pkg::*;
#(
  parameter int F = FP_FRAC_W
) (
  input  logic [F-1:0] frac,
  input  logic         guard,
  input  logic         sticky,
  input  logic         sign,
  input  rm_e          rm,
  output logic [F-1:0] frac_out,
  output logic         carry
);

  logic inc;

  always_comb begin
    inc = 1'b0;
    case (rm)
      RM_RNE:  inc = guard & (sticky | frac[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = (guard | sticky) & ~sign;
      RM_RDN:  inc = (guard | sticky) & sign;
      default: inc = 1'b0;
    endcase
    {carry, frac_out} = {1'b0, frac} + {{F{1'b0}}, inc};
  end

endmodule

// File: rtl/fpmul_round_pack.sv
// rtl/fpmul_round_pack.sv - FP16 multiply normalize/round/pack, 2-stage valid/ready pipeline
// Optional rounding-mode input enabled by FPMUL_RMODE_EN (default: RNE only).
module fpmul_round_pack
  import fpu_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int EXP_W = FP_EXP_W,
  parameter int BIAS  = FP_BIAS
) (
  input logic               clock,
  input logic               reset_n,
  fpmul_round_pack_if.slave bus
);

  localparam int P  = 2 * WIDTH;
  localparam int F  = WIDTH - 1;
  localparam int EW = EXP_W + 3;
  localparam int RW = EXP_W + WIDTH;
  // all-ones exponent field for an IEEE-style format
  localparam logic [EW-1:0] EXP_MAX = EW'(2 * BIAS + 1);

  logic          s1_valid, s1_adv;
  logic [F-1:0]  s1_frac;
  logic          s1_guard, s1_sticky, s1_sign, s1_nan, s1_inf, s1_zero, s1_pzero;
  logic [EW-1:0] s1_exp;
  rm_e           s1_rm;

  logic          s2_valid, s2_ovf, s2_unf, s2_inx;
  logic [RW-1:0] s2_result;

  logic          n_hi, n_guard, n_sticky;
  logic [F-1:0]  n_frac;
  logic [EW-1:0] n_exp;

  logic [F-1:0]  r_frac;
  logic          r_carry, ovf, unf, sat;
  logic [EW-1:0] r_exp;
  logic [RW-1:0] n2_result;
  logic [2:0]    n2_flags;

  assign s1_adv       = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s1_adv;

  always_comb begin
    n_hi     = bus.prod[P-1];
    n_frac   = n_hi ? bus.prod[P-2 -: F] : bus.prod[P-3 -: F];
    n_guard  = n_hi ? bus.prod[P-2-F] : bus.prod[P-3-F];
    n_sticky = n_hi ? |bus.prod[P-3-F:0] : |bus.prod[P-4-F:0];
    n_exp    = {bus.exp_in[EXP_W+1], bus.exp_in} + EW'(n_hi);
  end

  fpmul_round_inc #(.F(F)) u_inc (
    .frac     (s1_frac),
    .guard    (s1_guard),
    .sticky   (s1_sticky),
    .sign     (s1_sign),
    .rm       (s1_rm),
    .frac_out (r_frac),
    .carry    (r_carry)
  );

`ifdef FPMUL_RMODE_EN
  // directed-away-from-infinity modes saturate to max finite on overflow
  assign sat = (s1_rm == RM_RTZ) || (s1_rm == RM_RUP && s1_sign) || (s1_rm == RM_RDN && !s1_sign);
`else
  assign s1_rm = RM_RNE;
  assign sat   = 1'b0;
`endif

  always_comb begin
    r_exp     = s1_exp + EW'(r_carry);
    ovf       = !r_exp[EW-1] && (r_exp >= EXP_MAX);
    unf       = s1_pzero || r_exp[EW-1] || (r_exp == '0);
    n2_result = {s1_sign, r_exp[EXP_W-1:0], r_frac};
    n2_flags  = {2'b00, s1_guard | s1_sticky};
    if (s1_nan) begin
      n2_result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(F-1){1'b0}}};
      n2_flags  = 3'b000;
    end else if (s1_inf) begin
      n2_result = {s1_sign, {EXP_W{1'b1}}, {F{1'b0}}};
      n2_flags  = 3'b000;
    end else if (s1_zero) begin
      n2_result = {s1_sign, {(RW-1){1'b0}}};
      n2_flags  = 3'b000;
    end else if (unf) begin
      n2_result = {s1_sign, {(RW-1){1'b0}}};
      n2_flags  = 3'b011;
    end else if (ovf) begin
      n2_result = sat ? {s1_sign, {(EXP_W-1){1'b1}}, 1'b0, {F{1'b1}}}
                      : {s1_sign, {EXP_W{1'b1}}, {F{1'b0}}};
      n2_flags  = 3'b101;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_frac   <= '0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_exp    <= '0;
      s1_sign   <= 1'b0;
      s1_nan    <= 1'b0;
      s1_inf    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_pzero  <= 1'b0;
`ifdef FPMUL_RMODE_EN
      s1_rm     <= RM_RNE;
`endif
      s2_valid  <= 1'b0;
      s2_result <= '0;
      {s2_ovf, s2_unf, s2_inx} <= 3'b000;
    end else begin
      if (s1_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_result <= n2_result;
          {s2_ovf, s2_unf, s2_inx} <= n2_flags;
        end
      end
      if (bus.in_ready) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_frac   <= n_frac;
          s1_guard  <= n_guard;
          s1_sticky <= n_sticky;
          s1_exp    <= n_exp;
          s1_sign   <= bus.sign_in;
          s1_nan    <= bus.is_nan;
          s1_inf    <= bus.is_inf;
          s1_zero   <= bus.is_zero;
          s1_pzero  <= ~|bus.prod;
`ifdef FPMUL_RMODE_EN
          s1_rm     <= rm_e'(bus.rm);
`endif
        end
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.result    = s2_result;
  assign bus.flag_ovf  = s2_ovf;
  assign bus.flag_unf  = s2_unf;
  assign bus.flag_inx  = s2_inx;

endmodule

// File: tb/tb_fpmul_round_pack.sv
// tb/tb_fpmul_round_pack.sv - scoreboard bench for fpmul_round_pack (covers FPMUL_RMODE_EN when defined)
module tb_fpmul_round_pack;

  typedef struct {
    string       name;
    logic [18:0] val;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
`ifdef FPMUL_RMODE_EN
  logic [1:0] rm_sel = 2'b00;
`endif

  fpmul_round_pack_if #(.WIDTH(11), .EXP_W(5)) bus ();

  fpmul_round_pack dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic drive(input logic [21:0] p, input logic [6:0] e, input logic s,
                       input logic n, input logic i, input logic z);
    bus.prod     = p;
    bus.exp_in   = e;
    bus.sign_in  = s;
    bus.is_nan   = n;
    bus.is_inf   = i;
    bus.is_zero  = z;
`ifdef FPMUL_RMODE_EN
    bus.rm       = rm_sel;
`endif
    bus.in_valid = 1'b1;
  endtask

  task automatic send(input string name, input logic [21:0] p, input logic [6:0] e,
                      input logic s, input logic n, input logic i, input logic z,
                      input logic [15:0] res, input logic [2:0] fl);
    int waitc = 0;
    @(negedge clock);
    drive(p, e, s, n, i, z);
    while (!bus.in_ready && waitc < 200) begin
      @(negedge clock);
      waitc++;
    end
    if (waitc >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s accept: in_ready stuck at 0, required 1", name);
    end
    sb.push_back('{name, {res, fl}});
    @(posedge clock);
  endtask

  task automatic idle();
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    chk("drain queue empty", 32'(sb.size()), 32'd0);
  endtask

  // monitor: a beat presented with out_ready high transfers on the next rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (reset_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected beat: got %h expected none",
                   {bus.result, bus.flag_ovf, bus.flag_unf, bus.flag_inx});
        end else begin
          e = sb.pop_front();
          chk(e.name, 32'({bus.result, bus.flag_ovf, bus.flag_unf, bus.flag_inx}), 32'(e.val));
        end
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(22'h0, 7'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset result", 32'(bus.result), 32'h0);
    chk("reset flags", 32'({bus.flag_ovf, bus.flag_unf, bus.flag_inx}), 32'd0);
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    reset_n = 1'b1;

    send("1.5x1.5", 22'h240000, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4080, 3'b000);
    idle();
    chk("latency 1clk out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clock);
    chk("latency 2clk out_valid", 32'(bus.out_valid), 32'd1);
    drain();

    send("1.0x1.0",      22'h100000, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3C00, 3'b000);
    send("inexact",      22'h100801, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3C02, 3'b001);
    send("carry",        22'h3FFFFF, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4400, 3'b001);
    send("overflow",     22'h240000, 7'd30, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7C00, 3'b101);
    send("underflow",    22'h100000, 7'd0,  1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'b011);
    send("neg exp unf",  22'h100000, 7'h7D, 1'b1, 1'b0, 1'b0, 1'b0, 16'h8000, 3'b011);
    send("max exp",      22'h100000, 7'd30, 1'b1, 1'b0, 1'b0, 1'b0, 16'hF800, 3'b000);
    send("min exp",      22'h100000, 7'd1,  1'b0, 1'b0, 1'b0, 1'b0, 16'h0400, 3'b000);
    send("tie even",     22'h100200, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3C00, 3'b001);
    send("tie odd",      22'h100600, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3C02, 3'b001);
    send("nan over inf", 22'h240000, 7'd15, 1'b1, 1'b1, 1'b1, 1'b0, 16'h7E00, 3'b000);
    send("neg inf",      22'h240000, 7'd15, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFC00, 3'b000);
    send("neg zero",     22'h240000, 7'd15, 1'b1, 1'b0, 1'b0, 1'b1, 16'h8000, 3'b000);
    send("prod zero",    22'h000000, 7'd15, 1'b1, 1'b0, 1'b0, 1'b0, 16'h8000, 3'b011);
`ifdef FPMUL_RMODE_EN
    rm_sel = 2'b01;
    send("rtz overflow", 22'h240000, 7'd30, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7BFF, 3'b101);
    rm_sel = 2'b10;
    send("rup neg ovf",  22'h240000, 7'd30, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFBFF, 3'b101);
    send("rup pos inx",  22'h100801, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3C03, 3'b001);
    rm_sel = 2'b11;
    send("rdn neg inx",  22'h100801, 7'd15, 1'b1, 1'b0, 1'b0, 1'b0, 16'hBC03, 3'b001);
    rm_sel = 2'b00;
`endif
    idle();
    drain();

    // backpressure: third beat must stall with both stages full
    @(negedge clock);
    bus.out_ready = 1'b0;
    send("bp A", 22'h240000, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4080, 3'b000);
    send("bp B", 22'h100000, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3C00, 3'b000);
    @(negedge clock);
    drive(22'h3FFFFF, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    sb.push_back('{"bp C", {16'h4400, 3'b001}});
    for (int k = 0; k < 3; k++) begin
      chk("bp in_ready low", 32'(bus.in_ready), 32'd0);
      chk("bp out_valid held", 32'(bus.out_valid), 32'd1);
      chk("bp result stable", 32'(bus.result), 32'h4080);
      @(negedge clock);
    end
    bus.out_ready = 1'b1;
    @(posedge clock);
    idle();
    drain();

    // reset with both stages occupied drops the in-flight beats
    @(negedge clock);
    bus.out_ready = 1'b0;
    send("rst D", 22'h100000, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3C00, 3'b000);
    send("rst E", 22'h240000, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4080, 3'b000);
    idle();
    chk("pre-reset out_valid", 32'(bus.out_valid), 32'd1);
    reset_n = 1'b0;
    sb.delete();
    #1;
    chk("mid reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid reset result", 32'(bus.result), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clock);
    chk("post reset out_valid", 32'(bus.out_valid), 32'd0);
    send("post reset F", 22'h100801, 7'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3C02, 3'b001);
    idle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpmul_round_pack.md
Name: fpmul_round_pack

Overview:
- Post-multiply stage of the FP16 multiply datapath.
- Consumes the WIDTH×WIDTH significand product from the radix-4 Booth multiplier, plus the biased exponent sum, sign and special-case flags.
- Normalizes, rounds and packs the result into an IEEE-style half-precision word.
- Two-stage valid/ready pipeline with full backpressure, feeding the FPU result bus.

Parameters:
- WIDTH, 11, significand width including hidden bit; product is 2*WIDTH bits.
- EXP_W, 5, exponent field width.
- BIAS, 15, exponent bias (informational; exp_in arrives already re-biased).

Ports:
- clock  in  1  rising-edge clock; samples multiplier output registered on its negedge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- prod  in  2*WIDTH  unsigned significand product.
- exp_in  in  EXP_W+2  signed; ea+eb-BIAS.
- sign_in  in  1  sa^sb.
- is_nan  in  1  special: NaN result.
- is_inf  in  1  special: infinite result.
- is_zero  in  1  special: zero result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  1+EXP_W+WIDTH-1  packed {sign, exp, frac}.
- flag_ovf  out  1  overflow.
- flag_unf  out  1  underflow, flushed to zero.
- flag_inx  out  1  inexact.

Behaviour:
- Reset (async, reset_n=0): both stage valids=0; out_valid=0; result=0; all flags=0. Reset mid-operation drops in-flight beats.
- Handshake: transfer in on in_valid&&in_ready; out on out_valid&&out_ready.
  - in_ready = !s1_valid || s1 advances.
  - s1 advances when !s2_valid || out_ready.
  - Latency 2 clocks with no stall; throughput 1 per clock.
  - result/flags held stable while out_valid&&!out_ready. Order preserved.
- Stage 1, normalize (P=2*WIDTH, F=WIDTH-1):
  - prod[P-1]=1: frac=prod[P-2:P-1-F], guard=prod[P-2-F], sticky=|prod[P-3-F:0], e=exp_in+1.
  - Otherwise: frac=prod[P-3:P-2-F], guard=prod[P-3-F], sticky=|prod[P-4-F:0], e=exp_in.
  - Captures sign and specials.
- Stage 2, round (RNE): inc = guard&&(sticky||frac[0]).
  - frac all ones and inc=1: frac=0, e=e+1.
  - Then: e>=2^EXP_W-1 gives ±inf, flag_ovf=1, flag_inx=1. e<=0 gives signed zero, flag_unf=1, flag_inx=1.
  - Otherwise pack; flag_inx = guard|sticky.
- Specials override arithmetic, priority nan > inf > zero; all flags 0.
  - nan: 0x7E00 form (sign 0, exp all ones, frac MSB 1).
  - inf: {sign, all ones, 0}.
  - zero: {sign, 0, 0}.
- prod=0 without is_zero: treated as underflow to signed zero.
- No subnormal generation: flush-to-zero only.

Optional Feature:
- Macro FPMUL_RMODE_EN.
- Defined: extra input port rm[1:0], captured with the beat in stage 1.
  - 00 RNE; 01 RTZ (inc=0); 10 RUP (inc=(guard|sticky)&&!sign); 11 RDN (inc=(guard|sticky)&&sign).
  - On overflow, RTZ, RUP-negative and RDN-positive produce ±max finite (exp 2^EXP_W-2, frac all ones) instead of inf.
- Undefined: no rm port; RNE fixed.

Decomposition:
- Package fpu_pkg:
  - FP16 field widths and BIAS.
  - Canonical NaN constant.
  - Rounding-mode encodings (RM_RNE/RTZ/RUP/RDN).
  - Max-finite and inf constants.
- Sub-module fpmul_round_inc: combinational increment decision plus frac carry; reusable by the adder's rounder.

Test Plan:
- 1.5×1.5: prod=0x240000, exp_in=15 -> result=0x4080, flags 0, out_valid 2 clocks after acceptance.
- 1.0×1.0: prod=0x100000, exp_in=15 -> 0x3C00. (1+2^-10)²: prod=0x100801 -> 0x3C02, flag_inx=1.
- Carry: prod=0x3FFFFF, exp_in=15 -> 0x4400, flag_inx=1. Overflow: prod=0x240000, exp_in=30 -> 0x7C00, flag_ovf=1. Underflow: prod=0x100000, exp_in=0 -> 0x0000, flag_unf=1.
- Specials: is_nan with is_inf -> 0x7E00; is_inf, sign 1 -> 0xFC00; is_zero, sign 1 -> 0x8000.
- Backpressure: out_ready=0, offer 3 beats -> 2 accepted, in_ready=0, result stable. Release -> all 3 emerge in order, none lost or duplicated.
- Reset asserted with both stages full -> out_valid=0 immediately. After release, first new beat emerges alone. With FPMUL_RMODE_EN: rm=01, overflow case -> 0x7BFF.
